window3x3_gen: RTL and testbench

Streaming 3x3 neighbourhood generator for the pixel pipeline. Sits directly downstream of the byte unpacker that emits 9-bit {valid, pixel} tokens. Sits upstream of the kernel arithmetic. Buffers the two previous image rows in on-chip line memories and presents, for every interior pixel position, the full 3x3 window in one registered word.

---
 rtl/window3x3_gen.sv | 117 +++++++++++
 tb/tb_window3x3_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line memories plus a 3x3 shift
// window, emitting one registered window per interior pixel, 2 cycles after it.
module window3x3_gen #(
  parameter int PIXEL_WIDTH = 8,
  parameter int MAX_WIDTH   = 1024,
  parameter int COL_WIDTH   = 10
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [PIXEL_WIDTH:0]       data_in,
  input  logic [31:0]                image_width,
  output logic [9*PIXEL_WIDTH-1:0]   win_out,
  output logic                       win_valid,
  output logic                       width_err
);

  localparam logic [31:0] MAX_W_C = 32'(MAX_WIDTH);

  logic [COL_WIDTH-1:0]   col_q, col_d;
  logic [1:0]             row_q, row_d;
  logic                   width_err_q;
  logic                   bad_width_s;
  logic                   accept_s;
  logic                   last_col_s;
  logic                   emit_s;

  logic [PIXEL_WIDTH-1:0] lb0_mem [MAX_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1_mem [MAX_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb0_rd_q, lb1_rd_q, pix_q;

  logic                   s1_valid_q, s1_emit_q, s2_emit_q;
  logic [PIXEL_WIDTH-1:0] win_q [9];
  logic [9*PIXEL_WIDTH-1:0] win_out_q;
  logic                   win_valid_q;

  assign bad_width_s = (image_width < 32'd3) || (image_width > MAX_W_C);
  assign accept_s    = data_in[PIXEL_WIDTH] && !bad_width_s && !width_err_q;
  assign last_col_s  = ({{(32-COL_WIDTH){1'b0}}, col_q} == (image_width - 32'd1));
  // The col >= 2 gate also keeps the previous row's tail out of any window.
  assign emit_s      = (row_q == 2'd2) && (col_q >= COL_WIDTH'(2));

  // Column/row counter next state; row saturates once two rows are buffered.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept_s) begin
      if (last_col_s) begin
        col_d = {COL_WIDTH{1'b0}};
        if (row_q != 2'd2) begin
          row_d = row_q + 2'd1;
        end else begin
          row_d = row_q;
        end
      end else begin
        col_d = col_q + COL_WIDTH'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  // Line memories: read-before-write at col, not reset (row gate masks stale data).
  always_ff @(posedge clock) begin
    if (accept_s && !reset) begin
      lb1_rd_q         <= lb1_mem[col_q];
      lb0_rd_q         <= lb0_mem[col_q];
      pix_q            <= data_in[PIXEL_WIDTH-1:0];
      lb1_mem[col_q]   <= lb0_mem[col_q];
      lb0_mem[col_q]   <= data_in[PIXEL_WIDTH-1:0];
    end
  end

  // Counters, pipeline flags, window shift register and output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= {COL_WIDTH{1'b0}};
      row_q       <= 2'd0;
      width_err_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_emit_q   <= 1'b0;
      s2_emit_q   <= 1'b0;
      win_valid_q <= 1'b0;
      win_out_q   <= {(9*PIXEL_WIDTH){1'b0}};
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= {PIXEL_WIDTH{1'b0}};
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      width_err_q <= width_err_q || bad_width_s;
      s1_valid_q  <= accept_s;
      s1_emit_q   <= accept_s && emit_s;
      s2_emit_q   <= s1_emit_q;
      win_valid_q <= s2_emit_q;
      if (s1_valid_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]   <= win_q[3*r+1];
          win_q[3*r+1] <= win_q[3*r+2];
        end
        win_q[2] <= lb1_rd_q;
        win_q[5] <= lb0_rd_q;
        win_q[8] <= pix_q;
      end
      if (s2_emit_q) begin
        for (int k = 0; k < 9; k++) begin
          win_out_q[k*PIXEL_WIDTH +: PIXEL_WIDTH] <= win_q[k];
        end
      end
    end
  end

  assign win_out   = win_out_q;
  assign win_valid = win_valid_q;
  assign width_err = width_err_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen: frames streamed with/without bubbles,
// windows and their arrival cycles compared against a spatial reference.
module tb_window3x3_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  data_in = 9'd0;
  logic [31:0] image_width = 32'd4;
  logic [71:0] win_out;
  logic        win_valid;
  logic        width_err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  logic [7:0]  frame_q[$];
  int          exp_cyc[$];
  logic [71:0] got_win[$];
  int          got_cyc[$];

  window3x3_gen #(.PIXEL_WIDTH(8), .MAX_WIDTH(1024), .COL_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .image_width(image_width),
    .win_out(win_out), .win_valid(win_valid), .width_err(width_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (win_valid === 1'b1) begin
      got_win.push_back(win_out);
      got_cyc.push_back(cyc);
    end
  end

  function automatic logic [71:0] pk(input logic [7:0] e0, e1, e2, e3, e4, e5, e6, e7, e8);
    return {e8, e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic logic [71:0] model_win(input int w, input int r, input int c);
    logic [71:0] m;
    m = 72'd0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        m[(3*i+j)*8 +: 8] = frame_q[(r-2+i)*w + (c-2+j)];
    return m;
  endfunction

  // Reset with a valid token presented in the same cycle (it must be dropped).
  task automatic do_reset(input logic [31:0] w);
    @(negedge clock);
    reset = 1'b1;
    image_width = w;
    data_in = {1'b1, 8'hAA};
    @(negedge clock);
    reset = 1'b0;
    data_in = 9'd0;
    got_win.delete();
    got_cyc.delete();
  endtask

  task automatic stream_frame(input int w, input int h, input int mode, input int maxbub);
    frame_q.delete();
    exp_cyc.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        logic [7:0] p;
        int nb;
        case (mode)
          0: p = 8'(w*r + c);
          1: p = 8'(w*r + c + 1);
          default: p = 8'(c % 256);
        endcase
        frame_q.push_back(p);
        nb = (maxbub > 0) ? $urandom_range(maxbub, 1) : 0;
        for (int b = 0; b < nb; b++) begin
          @(negedge clock);
          data_in = {1'b0, 8'($urandom)};
        end
        @(negedge clock);
        data_in = {1'b1, p};
        if (r >= 2 && c >= 2) exp_cyc.push_back(cyc + 1);
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      data_in = 9'd0;
    end
  endtask

  task automatic test_reset;
    do_reset(32'd4);
    vec_cnt++;
    if (win_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_win_valid got %b want 0", win_valid); end
    vec_cnt++;
    if (win_out !== 72'd0) begin err_cnt++; $display("FAIL reset_win_out got %h want 0", win_out); end
    vec_cnt++;
    if (width_err !== 1'b0) begin err_cnt++; $display("FAIL reset_width_err got %b want 0", width_err); end
  endtask

  task automatic test_clean_4x4;
    int n;
    do_reset(32'd4);
    stream_frame(4, 4, 0, 0);
    vec_cnt++;
    if (got_win.size() !== 4) begin err_cnt++; $display("FAIL clean_count got %0d want 4", got_win.size()); end
    n = 0;
    for (int r = 2; r < 4; r++) begin
      for (int c = 2; c < 4; c++) begin
        if (n < got_win.size()) begin
          vec_cnt++;
          if (got_win[n] !== model_win(4, r, c)) begin err_cnt++; $display("FAIL clean_win%0d got %h want %h", n, got_win[n], model_win(4, r, c)); end
          vec_cnt++;
          if (got_cyc[n] !== exp_cyc[n] + 2) begin err_cnt++; $display("FAIL clean_lat%0d got %0d want %0d", n, got_cyc[n], exp_cyc[n] + 2); end
        end
        n++;
      end
    end
    if (got_win.size() == 4) begin
      vec_cnt++;
      if (got_win[0] !== pk(0, 1, 2, 4, 5, 6, 8, 9, 10)) begin err_cnt++; $display("FAIL clean_first got %h want %h", got_win[0], pk(0, 1, 2, 4, 5, 6, 8, 9, 10)); end
      vec_cnt++;
      if (got_win[3] !== pk(5, 6, 7, 9, 10, 11, 13, 14, 15)) begin err_cnt++; $display("FAIL clean_last got %h want %h", got_win[3], pk(5, 6, 7, 9, 10, 11, 13, 14, 15)); end
    end
    vec_cnt++;
    if (win_out !== pk(5, 6, 7, 9, 10, 11, 13, 14, 15)) begin err_cnt++; $display("FAIL clean_hold got %h", win_out); end
  endtask

  task automatic test_bubbles;
    do_reset(32'd4);
    stream_frame(4, 4, 0, 3);
    vec_cnt++;
    if (got_win.size() !== 4) begin err_cnt++; $display("FAIL bub_count got %0d want 4", got_win.size()); end
    for (int n = 0; n < 4 && n < got_win.size(); n++) begin
      vec_cnt++;
      if (got_win[n] !== model_win(4, 2 + n/2, 2 + n%2)) begin err_cnt++; $display("FAIL bub_win%0d got %h want %h", n, got_win[n], model_win(4, 2 + n/2, 2 + n%2)); end
      vec_cnt++;
      if (got_cyc[n] !== exp_cyc[n] + 2) begin err_cnt++; $display("FAIL bub_lat%0d got %0d want %0d", n, got_cyc[n], exp_cyc[n] + 2); end
    end
  endtask

  task automatic test_min_width;
    do_reset(32'd3);
    stream_frame(3, 3, 1, 0);
    vec_cnt++;
    if (got_win.size() !== 1) begin err_cnt++; $display("FAIL min_count got %0d want 1", got_win.size()); end
    if (got_win.size() > 0) begin
      vec_cnt++;
      if (got_win[0] !== pk(1, 2, 3, 4, 5, 6, 7, 8, 9)) begin err_cnt++; $display("FAIL min_win got %h want %h", got_win[0], pk(1, 2, 3, 4, 5, 6, 7, 8, 9)); end
    end
  endtask

  task automatic test_invalid_width(input logic [31:0] w);
    do_reset(w);
    @(negedge clock);
    vec_cnt++;
    if (width_err !== 1'b1) begin err_cnt++; $display("FAIL badw_flag w=%0d got %b want 1", w, width_err); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      data_in = {1'b1, 8'(i)};
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      data_in = 9'd0;
    end
    vec_cnt++;
    if (got_win.size() !== 0) begin err_cnt++; $display("FAIL badw_windows w=%0d got %0d want 0", w, got_win.size()); end
    vec_cnt++;
    if (width_err !== 1'b1) begin err_cnt++; $display("FAIL badw_sticky w=%0d got %b want 1", w, width_err); end
  endtask

  task automatic test_reset_mid;
    do_reset(32'd4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      data_in = {1'b1, 8'(8'd100 + 8'(i))};
    end
    do_reset(32'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      vec_cnt++;
      if (win_valid !== 1'b0) begin err_cnt++; $display("FAIL mid_quiet%0d got %b want 0", i, win_valid); end
    end
    stream_frame(4, 4, 0, 0);
    vec_cnt++;
    if (got_win.size() !== 4) begin err_cnt++; $display("FAIL mid_count got %0d want 4", got_win.size()); end
    for (int n = 0; n < 4 && n < got_win.size(); n++) begin
      vec_cnt++;
      if (got_win[n] !== model_win(4, 2 + n/2, 2 + n%2)) begin err_cnt++; $display("FAIL mid_win%0d got %h want %h", n, got_win[n], model_win(4, 2 + n/2, 2 + n%2)); end
      vec_cnt++;
      if (got_cyc[n] !== exp_cyc[n] + 2) begin err_cnt++; $display("FAIL mid_lat%0d got %0d want %0d", n, got_cyc[n], exp_cyc[n] + 2); end
    end
  endtask

  task automatic test_max_width;
    int bad;
    do_reset(32'd1024);
    stream_frame(1024, 3, 2, 0);
    vec_cnt++;
    if (got_win.size() !== 1022) begin err_cnt++; $display("FAIL max_count got %0d want 1022", got_win.size()); end
    bad = 0;
    for (int n = 0; n < got_win.size() && n < 1022; n++)
      if (got_win[n] !== model_win(1024, 2, 2 + n)) bad++;
    vec_cnt++;
    if (bad !== 0) begin err_cnt++; $display("FAIL max_contents got %0d bad windows want 0", bad); end
    if (got_win.size() > 0) begin
      vec_cnt++;
      if (got_win[got_win.size()-1][23:0] !== {8'd255, 8'd254, 8'd253}) begin
        err_cnt++; $display("FAIL max_last_top got %h want fffefd", got_win[got_win.size()-1][23:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_4x4();
    test_bubbles();
    test_min_width();
    test_invalid_width(32'd2);
    test_invalid_width(32'd1025);
    test_reset_mid();
    test_max_width();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
